// File: rtl/lbm_run_scheduler_if.sv
// rtl/lbm_run_scheduler_if.sv - host/solver/DMA signal bundle for the LBM run scheduler
interface lbm_run_scheduler_if #(
    parameter int STEP_WIDTH     = 32,
    parameter int INTERVAL_WIDTH = 16
);
    logic                      start;
    logic                      abort;
    logic [STEP_WIDTH-1:0]     num_steps;
    logic [INTERVAL_WIDTH-1:0] dump_interval;
    logic                      solver_step_done;
    logic                      axis_tvalid;
    logic                      axis_tready;
    logic                      axis_tlast;
    logic                      solver_en;
    logic [STEP_WIDTH-1:0]     solver_step;
    logic                      dma_start;
    logic                      busy;
    logic                      done;
    logic [INTERVAL_WIDTH-1:0] frame_count;
    logic                      error;

    // Host / environment side
    modport master (
        output start, abort, num_steps, dump_interval, solver_step_done,
        output axis_tvalid, axis_tready, axis_tlast,
        input  solver_en, solver_step, dma_start, busy, done, frame_count, error
    );

    // Scheduler side
    modport slave (
        input  start, abort, num_steps, dump_interval, solver_step_done,
        input  axis_tvalid, axis_tready, axis_tlast,
        output solver_en, solver_step, dma_start, busy, done, frame_count, error
    );
endinterface

// File: rtl/lbm_run_scheduler.sv
// rtl/lbm_run_scheduler.sv - run sequencer pausing the LBM solver for periodic DMA frame dumps
// Optional DMA watchdog enabled by defining LBM_SCHED_TIMEOUT_EN.
module lbm_run_scheduler #(
    parameter int STEP_WIDTH     = 32,
    parameter int INTERVAL_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    lbm_run_scheduler_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DUMP, S_WAIT_DMA, S_FINISH
    } state_t;

    state_t                    state_q;
    logic [STEP_WIDTH-1:0]     num_steps_q;
    logic [STEP_WIDTH-1:0]     solver_step_q;
    logic [INTERVAL_WIDTH-1:0] interval_q;
    logic [INTERVAL_WIDTH-1:0] since_dump_q;
    logic [INTERVAL_WIDTH-1:0] frame_count_q;
    logic                      solver_en_q;
    logic                      dma_start_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      abort_pend_q;
`ifdef LBM_SCHED_TIMEOUT_EN
    logic [31:0]               timer_q;
    logic                      error_q;
`endif

    logic [STEP_WIDTH-1:0]     step_inc;
    logic [INTERVAL_WIDTH-1:0] since_inc;
    logic                      last;
    logic                      due;
    logic                      beat;

    always_comb begin
        step_inc  = solver_step_q + STEP_WIDTH'(1);
        since_inc = since_dump_q + INTERVAL_WIDTH'(1);
        last      = (step_inc == num_steps_q);
        due       = (interval_q != '0) && (since_inc == interval_q);
        beat      = bus.axis_tvalid && bus.axis_tready && bus.axis_tlast;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            num_steps_q   <= '0;
            solver_step_q <= '0;
            interval_q    <= '0;
            since_dump_q  <= '0;
            frame_count_q <= '0;
            solver_en_q   <= 1'b0;
            dma_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            abort_pend_q  <= 1'b0;
`ifdef LBM_SCHED_TIMEOUT_EN
            timer_q       <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            dma_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        num_steps_q   <= bus.num_steps;
                        interval_q    <= bus.dump_interval;
                        solver_step_q <= '0;
                        since_dump_q  <= '0;
                        frame_count_q <= '0;
                        busy_q        <= 1'b1;
`ifdef LBM_SCHED_TIMEOUT_EN
                        error_q       <= 1'b0;
`endif
                        // Zero-length runs enter FINISH with done low; it is raised a cycle later.
                        if (bus.num_steps == '0) begin
                            state_q <= S_FINISH;
                        end else begin
                            state_q     <= S_RUN;
                            solver_en_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state_q     <= S_IDLE;
                        solver_en_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (bus.solver_step_done) begin
                        solver_step_q <= step_inc;
                        // A dump on the final sweep takes priority; FINISH follows the frame.
                        if (due) begin
                            since_dump_q <= '0;
                            state_q      <= S_DUMP;
                            solver_en_q  <= 1'b0;
                        end else begin
                            since_dump_q <= since_inc;
                            if (last) begin
                                state_q     <= S_FINISH;
                                solver_en_q <= 1'b0;
                                done_q      <= 1'b1;
                            end
                        end
                    end
                end
                S_DUMP: begin
                    if (bus.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        dma_start_q  <= 1'b1;
                        abort_pend_q <= 1'b0;
                        state_q      <= S_WAIT_DMA;
`ifdef LBM_SCHED_TIMEOUT_EN
                        timer_q      <= '0;
`endif
                    end
                end
                S_WAIT_DMA: begin
                    if (beat) begin
                        frame_count_q <= frame_count_q + INTERVAL_WIDTH'(1);
                        abort_pend_q  <= 1'b0;
                        if (abort_pend_q || bus.abort) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (solver_step_q == num_steps_q) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= S_RUN;
                            solver_en_q <= 1'b1;
                        end
                    end else begin
                        // Abort must not truncate a frame in flight, so it is held until tlast.
                        if (bus.abort) begin
                            abort_pend_q <= 1'b1;
                        end
`ifdef LBM_SCHED_TIMEOUT_EN
                        if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                            error_q      <= 1'b1;
                            abort_pend_q <= 1'b0;
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 32'd1;
                        end
`endif
                    end
                end
                S_FINISH: begin
                    if (done_q || bus.abort) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    solver_en_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.solver_en   = solver_en_q;
    assign bus.solver_step = solver_step_q;
    assign bus.dma_start   = dma_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frame_count = frame_count_q;
`ifdef LBM_SCHED_TIMEOUT_EN
    assign bus.error       = error_q;
`else
    assign bus.error       = 1'b0;
`endif
endmodule

// File: tb/tb_lbm_run_scheduler.sv
// tb/tb_lbm_run_scheduler.sv - directed self-checking bench for lbm_run_scheduler
module tb_lbm_run_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   dma_cnt  = 0;
    int   done_cnt = 0;
    int   en_cnt   = 0;

    lbm_run_scheduler_if #(.STEP_WIDTH(32), .INTERVAL_WIDTH(16)) bus ();

    lbm_run_scheduler #(
        .STEP_WIDTH(32), .INTERVAL_WIDTH(16), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.dma_start === 1'b1) dma_cnt++;
        if (bus.done === 1'b1)      done_cnt++;
        if (bus.solver_en === 1'b1) en_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pulse();
        bus.solver_step_done = 1'b1;
        tick();
        bus.solver_step_done = 1'b0;
    endtask

    task automatic tlast_beat();
        bus.axis_tvalid = 1'b1;
        bus.axis_tready = 1'b1;
        bus.axis_tlast  = 1'b1;
        tick();
        bus.axis_tvalid = 1'b0;
        bus.axis_tready = 1'b0;
        bus.axis_tlast  = 1'b0;
    endtask

    task automatic run_start(input logic [31:0] n, input logic [15:0] iv);
        bus.num_steps     = n;
        bus.dump_interval = iv;
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic clear_mon();
        dma_cnt  = 0;
        done_cnt = 0;
        en_cnt   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench hung");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_steps = '0; bus.dump_interval = '0;
        bus.solver_step_done = 1'b0;
        bus.axis_tvalid = 1'b0; bus.axis_tready = 1'b0; bus.axis_tlast = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", bus.solver_en, 0);
        chk("rst_dma", bus.dma_start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_step", bus.solver_step, 0);
        chk("rst_frames", bus.frame_count, 0);
        chk("rst_error", bus.error, 0);
        rst = 1'b1;
        tick();

        // Basic run: 4 steps, dump every 2
        clear_mon();
        run_start(32'd4, 16'd2);
        chk("b_en_after_start", bus.solver_en, 1);
        chk("b_busy", bus.busy, 1);
        tick();
        step_pulse();
        chk("b_step1", bus.solver_step, 1);
        chk("b_en_step1", bus.solver_en, 1);
        tick();
        step_pulse();
        chk("b_en_dump1", bus.solver_en, 0);
        chk("b_dma_early", bus.dma_start, 0);
        tick();
        chk("b_dma1", bus.dma_start, 1);
        chk("b_step2", bus.solver_step, 2);
        for (int i = 0; i < 9; i++) tick();
        chk("b_en_wait1", bus.solver_en, 0);
        tlast_beat();
        chk("b_frames1", bus.frame_count, 1);
        chk("b_en_resume", bus.solver_en, 1);
        step_pulse();
        tick();
        step_pulse();
        chk("b_en_dump2", bus.solver_en, 0);
        tick();
        chk("b_dma2", bus.dma_start, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("b_en_wait2", bus.solver_en, 0);
        tlast_beat();
        chk("b_done", bus.done, 1);
        chk("b_frames2", bus.frame_count, 2);
        tick();
        chk("b_busy_end", bus.busy, 0);
        chk("b_done_end", bus.done, 0);
        chk("b_dma_count", dma_cnt, 2);
        chk("b_done_count", done_cnt, 1);

        // No dumps: 3 steps, interval 0
        clear_mon();
        run_start(32'd3, 16'd0);
        step_pulse();
        tick();
        step_pulse();
        tick();
        step_pulse();
        chk("n_done", bus.done, 1);
        chk("n_step", bus.solver_step, 3);
        tick();
        chk("n_busy_end", bus.busy, 0);
        chk("n_dma_count", dma_cnt, 0);

        // Zero-length run
        clear_mon();
        run_start(32'd0, 16'd2);
        chk("z_done_c1", bus.done, 0);
        chk("z_busy_c1", bus.busy, 1);
        tick();
        chk("z_done_c2", bus.done, 1);
        tick();
        chk("z_busy_end", bus.busy, 0);
        chk("z_en_count", en_cnt, 0);

        // Abort during WAIT_DMA
        clear_mon();
        run_start(32'd4, 16'd1);
        step_pulse();
        tick();
        chk("a_dma", bus.dma_start, 1);
        bus.abort = 1'b1;
        tick(); tick();
        bus.abort = 1'b0;
        tick();
        chk("a_held_busy", bus.busy, 1);
        chk("a_held_en", bus.solver_en, 0);
        tlast_beat();
        chk("a_busy_after", bus.busy, 0);
        chk("a_frames", bus.frame_count, 1);
        tick();
        chk("a_done_count", done_cnt, 0);

        // start && abort in IDLE
        bus.start = 1'b1; bus.abort = 1'b1; bus.num_steps = 32'd5;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        chk("sa_en", bus.solver_en, 0);

        // start mid-run ignored
        clear_mon();
        run_start(32'd2, 16'd0);
        bus.num_steps = 32'd5;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        step_pulse();
        tick();
        step_pulse();
        chk("m_done", bus.done, 1);
        chk("m_step", bus.solver_step, 2);
        tick();

        // Asynchronous reset mid-run
        run_start(32'd5, 16'd0);
        chk("r_en_before", bus.solver_en, 1);
        #2 rst = 1'b0;
        #1;
        chk("r_en", bus.solver_en, 0);
        chk("r_busy", bus.busy, 0);
        chk("r_dma", bus.dma_start, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("r_idle", bus.busy, 0);

`ifdef LBM_SCHED_TIMEOUT_EN
        // DMA watchdog
        begin
            int waited = 0;
            clear_mon();
            run_start(32'd2, 16'd1);
            step_pulse();
            tick();
            chk("t_dma", bus.dma_start, 1);
            while (bus.busy === 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            chk("t_window", (waited >= 98 && waited <= 101), 1);
            chk("t_error", bus.error, 1);
            chk("t_frames", bus.frame_count, 0);
            chk("t_done_count", done_cnt, 0);
            run_start(32'd0, 16'd0);
            chk("t_error_clr", bus.error, 0);
            tick(); tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
